// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Only one request is ever outstanding, so no request tag is carried.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one imem read at a time
// and registers the returned word for decode; redirects squash in-flight fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  if_stage_if.master         imem,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [6:0]         if_opcode,
  output logic               fetch_misalign
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned ILEN_B = 4;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              misalign_q, misalign_d;
  logic              req_c;
  logic [XLEN-1:0]   target_c;

  // Backpressure and redirects both hold off new requests
  assign req_c    = !rst && (state_q == S_FETCH) && !redirect && (!valid_q || if_ready);
  assign target_c = {redirect_pc[XLEN-1:2], 2'b00};

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ipc_q      <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    misalign_d = redirect && (redirect_pc[1:0] != 2'b00);

    // Decode consumed the held instruction
    if (valid_q && if_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = target_c;
        end else if (req_c && imem.imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target_c;
          if (imem.imem_rvalid) begin
            state_d = S_FETCH;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          state_d = S_FETCH;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            instr_d = imem.imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_q + XLEN'(ILEN_B);
          end
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Squash wins over delivery
    if (redirect) begin
      valid_d = 1'b0;
    end
    if (!valid_d) begin
      instr_d = NOP_INSTR;
    end
  end

  assign if_valid       = valid_q;
  assign if_instr       = instr_q;
  assign if_pc          = ipc_q;
  assign if_opcode      = instr_q[OPC_W-1:0];
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: table-driven straight-line fetch plus
// hand-written redirect, squash, misalign and reset-in-WAIT sequences.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic        fetch_misalign;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Memory responder state
  bit          auto_resp;
  bit          pend;
  int          lat;
  int          cnt;
  logic [31:0] paddr;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vt[9];

  // Opcode cycles R-type, load, op-imm, jalr by word index; upper bits tag the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0:    op = 7'b0110011;
      2'd1:    op = 7'b0000011;
      2'd2:    op = 7'b0010011;
      default: op = 7'b1100111;
    endcase
    return {a[24:0], op};
  endfunction

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: sample acceptance at negedge, drive responses just after posedge
  task automatic tick();
    @(negedge clk);
    if (auto_resp && imem_bus.imem_req && imem_bus.imem_ready) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_bus.imem_addr;
    end
    @(posedge clk);
    #1;
    if (auto_resp) begin
      imem_bus.imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = mem_word(paddr);
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [31:0] pc,
                           input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    check_b({tag, "_valid"}, if_valid, vld);
    check_w({tag, "_instr"}, if_instr, instr);
    check_w({tag, "_opcode"}, 32'(if_opcode), 32'(op));
    if (vld) check_w({tag, "_pc"}, if_pc, pc);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h13};
    vt[1] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h13};
    vt[2] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 32'h33};
    vt[3] = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h0, 32'h13};
    vt[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 32'h203};
    vt[5] = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h0, 32'h13};
    vt[6] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 32'h413};
    vt[7] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h0, 32'h13};
    vt[8] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'hC, 32'h667};

    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b1;
    imem_bus.imem_ready  = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    auto_resp = 1'b1;
    pend = 1'b0;
    lat = 1;
    cnt = 0;
    paddr = 32'h0;

    @(posedge clk);
    #1;
    settle();
    check_b("rst_req", imem_bus.imem_req, 1'b0);
    check_out("rst", 1'b0, 32'h0, 32'h13);
    check_w("rst_pc", if_pc, 32'h0);
    check_b("rst_misalign", fetch_misalign, 1'b0);
    tick();
    rst = 1'b0;

    // Straight-line fetch with zero-wait memory, then backpressure starts at row 8
    for (int i = 0; i < 9; i++) begin
      if_ready = vt[i].rdy;
      settle();
      check_b($sformatf("seq%0d_req", i), imem_bus.imem_req, vt[i].req);
      check_w($sformatf("seq%0d_addr", i), imem_bus.imem_addr, vt[i].addr);
      check_out($sformatf("seq%0d", i), vt[i].vld, vt[i].pc, vt[i].instr);
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      settle();
      check_b($sformatf("stall%0d_req", i), imem_bus.imem_req, 1'b0);
      check_out($sformatf("stall%0d", i), 1'b1, 32'hC, 32'h667);
      tick();
    end

    if_ready = 1'b1;
    settle();
    check_b("resume_req", imem_bus.imem_req, 1'b1);
    check_w("resume_addr", imem_bus.imem_addr, 32'h10);
    tick();
    settle();
    check_b("resume_wait_valid", if_valid, 1'b0);
    tick();
    settle();
    check_out("resume", 1'b1, 32'h10, mem_word(32'h10));
    check_w("resume_next_addr", imem_bus.imem_addr, 32'h14);

    // Redirect while WAITing on a 3-cycle memory
    lat = 3;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    settle();
    check_b("rdw_req", imem_bus.imem_req, 1'b0);
    check_b("rdw_valid0", if_valid, 1'b0);
    tick();
    redirect = 1'b0;
    settle();
    check_w("rdw_addr", imem_bus.imem_addr, 32'h100);
    check_b("rdw_req_wait", imem_bus.imem_req, 1'b0);
    check_b("rdw_valid1", if_valid, 1'b0);
    tick();
    settle();
    check_b("rdw_stale_rvalid", imem_bus.imem_rvalid, 1'b1);
    check_b("rdw_valid2", if_valid, 1'b0);
    lat = 1;
    tick();
    settle();
    check_b("rdw_valid3", if_valid, 1'b0);
    check_b("rdw_refetch_req", imem_bus.imem_req, 1'b1);
    check_w("rdw_refetch_addr", imem_bus.imem_addr, 32'h100);
    tick();
    settle();
    check_b("rdw_valid4", if_valid, 1'b0);
    tick();
    settle();
    check_out("rdw_target", 1'b1, 32'h100, 32'h8033);

    // Redirect coincident with a valid instruction being consumed
    redirect = 1'b1;
    redirect_pc = 32'h200;
    settle();
    check_b("sq_req", imem_bus.imem_req, 1'b0);
    tick();
    redirect = 1'b0;
    settle();
    check_out("sq_killed", 1'b0, 32'h0, 32'h13);
    check_b("sq_req2", imem_bus.imem_req, 1'b1);
    check_w("sq_addr", imem_bus.imem_addr, 32'h200);
    check_b("sq_misalign", fetch_misalign, 1'b0);
    tick();
    tick();
    settle();
    check_out("sq_target", 1'b1, 32'h200, mem_word(32'h200));

    // Misaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    settle();
    check_b("mis_pulse", fetch_misalign, 1'b1);
    check_w("mis_addr", imem_bus.imem_addr, 32'h100);
    check_b("mis_valid", if_valid, 1'b0);
    tick();
    settle();
    check_b("mis_pulse_end", fetch_misalign, 1'b0);
    tick();
    settle();
    check_out("mis_target", 1'b1, 32'h100, 32'h8033);

    // Reset while WAITing, late response after reset drops
    lat = 3;
    tick();
    auto_resp = 1'b0;
    pend = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    rst = 1'b1;
    tick();
    settle();
    check_b("rw_req", imem_bus.imem_req, 1'b0);
    check_out("rw_rst", 1'b0, 32'h0, 32'h13);
    check_w("rw_pc", if_pc, 32'h0);
    imem_bus.imem_ready = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    check_b("rw_req_after", imem_bus.imem_req, 1'b1);
    check_w("rw_addr_after", imem_bus.imem_addr, 32'h0);
    tick();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEADBEEF;
    settle();
    check_b("rw_late_valid0", if_valid, 1'b0);
    tick();
    imem_bus.imem_rvalid = 1'b0;
    settle();
    check_out("rw_ignored", 1'b0, 32'h0, 32'h13);
    imem_bus.imem_ready = 1'b1;
    lat = 1;
    auto_resp = 1'b1;
    settle();
    check_b("rw_req2", imem_bus.imem_req, 1'b1);
    check_w("rw_addr2", imem_bus.imem_addr, 32'h0);
    tick();
    tick();
    settle();
    check_out("rw_first", 1'b1, 32'h0, 32'h33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
